// File: rtl/rr_arbiter_4_pkg.sv
// rr_arbiter_4_pkg: shared state encodings and widths for the round-robin arbiter family.
package rr_arbiter_4_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
    localparam int ARB_N = 4;
    localparam int ARB_IDX_W = 2;
    localparam int CNT_W = 8;
endpackage

// File: rtl/rr_pick_4.sv
// rr_pick_4: combinational rotate-and-priority select; first set req bit at or after ptr (mod 4).
module rr_pick_4
    import rr_arbiter_4_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [ARB_IDX_W-1:0] win,
    output logic                 any
);
    always_comb begin
        win = ptr;
        // Walk the search order backwards so the earliest set bit is written last.
        for (int k = ARB_N - 1; k >= 0; k--)
            if (req[ptr + ARB_IDX_W'(k)]) win = ptr + ARB_IDX_W'(k);
        any = |req;
    end
endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter with registered one-hot grant and bounded hold time.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ARB_N-1:0]     req,
    input  logic                 done,
    output logic [ARB_N-1:0]     gnt,
    output logic                 gnt_valid,
    output logic [ARB_IDX_W-1:0] gnt_idx,
    output logic                 timeout
);
    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_MAX);

    state_t               state, state_n;
    logic [ARB_IDX_W-1:0] ptr, ptr_n, idx_n, win;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [ARB_N-1:0]     gnt_n;
    logic                 any, to_n, rel, hit;

    rr_pick_4 u_pick (.req(req), .ptr(ptr), .win(win), .any(any));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        to_n    = 1'b0;
        rel     = done || !req[gnt_idx];
        hit     = cnt == HOLD;
        if (state == ST_IDLE) begin
            if (any) begin
                state_n = ST_GRANT;
                gnt_n   = ARB_N'(1) << win;
                idx_n   = win;
                cnt_n   = CNT_W'(1);
            end
        end else if (rel || hit) begin
            // A voluntary release takes precedence over the hold-time limit.
            state_n = ST_IDLE;
            gnt_n   = '0;
            idx_n   = '0;
            ptr_n   = gnt_idx + ARB_IDX_W'(1);
            cnt_n   = '0;
            to_n    = !rel;
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            gnt_valid <= state_n == ST_GRANT;
            gnt_idx   <= idx_n;
            timeout   <= to_n;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed scenarios checked against a queue-free behavioural arbiter model every cycle.
module tb_rr_arbiter_4;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    int m_owner = -1;
    int m_ptr = 0;
    int m_held = 0;
    int m_to = 0;

    rr_arbiter_4 #(.HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int enc(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g == 4'(1 << i)) return i;
        return 0;
    endfunction

    // Model: owner index or -1, next-priority pointer, cycles held so far, timeout flag.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            for (int k = 0; k < 4; k++)
                if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_held = 1;
                end
        end else if (done || !req[m_owner]) begin
            m_to = 0; m_ptr = (m_owner + 1) % 4; m_owner = -1;
        end else if (m_held == HOLD) begin
            m_to = 1; m_ptr = (m_owner + 1) % 4; m_owner = -1;
        end else begin
            m_held++;
        end
    end

    always @(negedge clk) begin
        chk("gnt", int'(gnt), m_owner < 0 ? 0 : (1 << m_owner));
        chk("gnt_valid", int'(gnt_valid), m_owner >= 0 ? 1 : 0);
        chk("gnt_idx", int'(gnt_idx), m_owner < 0 ? 0 : m_owner);
        chk("timeout", int'(timeout), m_to);
        chk("onehot", int'($countones(gnt) <= 1), 1);
        if (gnt_valid) chk("enc_idx", int'(gnt_idx), enc(gnt));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int exp_g[5] = '{1, 2, 4, 8, 1};
        #1 rst_n = 1'b0;
        cyc(2);
        chk("rst_gnt", int'(gnt), 0);
        rst_n = 1'b1;
        // Full contention, done pulsed each grant: strict rotation with idle gaps.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("rot_gnt", int'(gnt), exp_g[i]);
            chk("rot_idx", int'(gnt_idx), i % 4);
            done = 1'b1;
            cyc(1);
            chk("rot_gap", int'(gnt), 0);
            done = 1'b0;
        end
        req = 4'b0000;
        cyc(2);
        // Hold-time revocation on a lone requester.
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("hold_gnt", int'(gnt), 4);
            chk("hold_to", int'(timeout), 0);
        end
        cyc(1);
        chk("to_gnt", int'(gnt), 0);
        chk("to_pulse", int'(timeout), 1);
        cyc(1);
        chk("regrant", int'(gnt), 4);
        chk("regrant_to", int'(timeout), 0);
        chk("regrant_ptr", int'(dut.ptr), 3);
        // done coincides with cnt == HOLD: release without timeout.
        cyc(2);
        done = 1'b1;
        cyc(1);
        chk("done_wins_gnt", int'(gnt), 0);
        chk("done_wins_to", int'(timeout), 0);
        done = 1'b0;
        req = 4'b0000;
        cyc(1);
        // Grantee 2 drops its request while requester 0 waits.
        req = 4'b0100;
        cyc(1);
        chk("drop_gnt", int'(gnt), 4);
        req = 4'b0101;
        cyc(1);
        req = 4'b0001;
        cyc(1);
        chk("drop_rel", int'(gnt), 0);
        cyc(1);
        chk("drop_next", int'(gnt), 1);
        done = 1'b1; req = 4'b0000;
        cyc(1);
        done = 1'b0; req = 4'b0010;
        cyc(1);
        chk("p2_setup", int'(gnt), 2);
        done = 1'b1; req = 4'b0000;
        cyc(1);
        done = 1'b0;
        chk("p2_ptr", int'(dut.ptr), 2);
        // Pointer at 2: requester 3 beats requester 1.
        req = 4'b1010;
        cyc(1);
        chk("ptr2_gnt", int'(gnt), 8);
        chk("ptr2_idx", int'(gnt_idx), 3);
        done = 1'b1; req = 4'b0000;
        cyc(1);
        done = 1'b0; req = 4'b0010;
        cyc(1);
        chk("rst_pre", int'(gnt), 2);
        // Asynchronous reset mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", int'(gnt), 0);
        chk("arst_valid", int'(gnt_valid), 0);
        chk("arst_idx", int'(gnt_idx), 0);
        chk("arst_to", int'(timeout), 0);
        req = 4'b0110;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk("post_rst", int'(gnt), 2);
        req = 4'b0000;
        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
